// File: rtl/adc_controller.sv
// AD7608 readout controller: CONVST/BUSY handshake, then dual-line serial capture of 8 channels.
// Define ADC_TIMEOUT_EN to bound the BUSY waits by T_TIMEOUT cycles (timeout_out otherwise stays 0).
module adc_controller #(
   parameter int W_DATA    = 18,
   parameter int W_CHS     = 3,
   parameter int N_CHAN    = 8,
   parameter int T_CONVST  = 4,
   parameter int T_RST     = 8,
   parameter int T_TIMEOUT = 1000
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              cstart_in,
   input  logic [2:0]        os_in,
   input  logic              busy_in,
   input  logic              douta_in,
   input  logic              doutb_in,
   output logic              cvst_out,
   output logic              ncs_out,
   output logic              sclk_out,
   output logic              adc_reset_out,
   output logic [2:0]        os_out,
   output logic              data_valid_out,
   output logic [W_DATA-1:0] data_a_out,
   output logic [W_CHS-1:0]  chan_a_out,
   output logic [W_DATA-1:0] data_b_out,
   output logic [W_CHS-1:0]  chan_b_out,
   output logic              cycle_done_out,
   output logic              timeout_out
);

   localparam int N_PER_LINE = N_CHAN / 2;
   localparam int C_CNT_MAX  = (T_TIMEOUT > T_RST) ?
                               ((T_TIMEOUT > T_CONVST) ? T_TIMEOUT : T_CONVST) :
                               ((T_RST > T_CONVST) ? T_RST : T_CONVST);
   localparam int W_CNT      = $clog2(C_CNT_MAX + 1);
   localparam int W_BIT      = $clog2(W_DATA);
   localparam int W_CH       = (N_PER_LINE > 1) ? $clog2(N_PER_LINE) : 1;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_IDLE,
      ST_CONVST,
      ST_WAIT_BUSY_HI,
      ST_WAIT_BUSY_LO,
      ST_CS_SETUP,
      ST_RX,
      ST_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [W_CNT-1:0]  r_cnt;
   logic              r_phase;
   logic [W_BIT-1:0]  r_bit;
   logic [W_CH-1:0]   r_chan;
   logic [W_DATA-1:0] r_sh_a;
   logic [W_DATA-1:0] r_sh_b;
   logic [W_DATA-1:0] r_data_a;
   logic [W_DATA-1:0] r_data_b;
   logic [W_CHS-1:0]  r_chan_a;
   logic [W_CHS-1:0]  r_chan_b;
   logic [2:0]        r_os;
   logic              r_valid;
   logic              r_done;
   logic              r_timeout;

   logic              w_chan_end;
   logic              w_frame_end;
   logic              w_wait_expired;
   logic              w_wait_abort;
   logic              w_cnt_keep;
   logic [W_DATA-1:0] w_sh_a;
   logic [W_DATA-1:0] w_sh_b;

   assign w_sh_a      = {r_sh_a[W_DATA-2:0], douta_in};
   assign w_sh_b      = {r_sh_b[W_DATA-2:0], doutb_in};
   assign w_chan_end  = (r_state == ST_RX) && r_phase && (r_bit == W_BIT'(W_DATA - 1));
   assign w_frame_end = w_chan_end && (r_chan == W_CH'(N_PER_LINE - 1));

`ifdef ADC_TIMEOUT_EN
   assign w_wait_expired = (r_cnt == W_CNT'(T_TIMEOUT - 1));
`else
   assign w_wait_expired = 1'b0;
`endif

   // The BUSY-high and BUSY-low waits share one budget, so the counter survives that transition.
   assign w_cnt_keep = (w_next == r_state) ||
                       ((r_state == ST_WAIT_BUSY_HI) && (w_next == ST_WAIT_BUSY_LO));

   always_ff @(posedge clk_in) begin
      if (reset_in) r_state <= ST_RESET;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_wait_abort = 1'b0;
      case (r_state)
         ST_RESET:        if (r_cnt == W_CNT'(T_RST - 1)) w_next = ST_IDLE;
         ST_IDLE:         if (cstart_in) w_next = ST_CONVST;
         ST_CONVST:       if (r_cnt == W_CNT'(T_CONVST - 1)) w_next = ST_WAIT_BUSY_HI;
         ST_WAIT_BUSY_HI: begin
            if (w_wait_expired) begin
               w_next       = ST_IDLE;
               w_wait_abort = 1'b1;
            end else if (busy_in) begin
               w_next = ST_WAIT_BUSY_LO;
            end
         end
         ST_WAIT_BUSY_LO: begin
            if (w_wait_expired) begin
               w_next       = ST_IDLE;
               w_wait_abort = 1'b1;
            end else if (!busy_in) begin
               w_next = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP:     w_next = ST_RX;
         ST_RX:           if (w_frame_end) w_next = ST_DONE;
         ST_DONE:         w_next = ST_IDLE;
         default:         w_next = ST_RESET;
      endcase
   end

   always_comb begin
      cvst_out      = 1'b1;
      ncs_out       = 1'b1;
      sclk_out      = 1'b1;
      adc_reset_out = 1'b0;
      case (r_state)
         ST_RESET:    adc_reset_out = 1'b1;
         ST_CONVST:   cvst_out      = 1'b0;
         ST_CS_SETUP: ncs_out       = 1'b0;
         ST_RX: begin
            ncs_out  = 1'b0;
            sclk_out = r_phase;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_cnt     <= '0;
         r_phase   <= 1'b0;
         r_bit     <= '0;
         r_chan    <= '0;
         r_sh_a    <= '0;
         r_sh_b    <= '0;
         r_data_a  <= '0;
         r_data_b  <= '0;
         r_chan_a  <= '0;
         r_chan_b  <= '0;
         r_os      <= '0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_keep ? r_cnt + 1'b1 : '0;
         r_valid   <= 1'b0;
         r_done    <= (r_state == ST_DONE);
         r_timeout <= w_wait_abort;
         if ((r_state == ST_IDLE) && cstart_in) r_os <= os_in;
         if (r_state == ST_RX) begin
            r_phase <= ~r_phase;
            // Sample at the edge ending phase 1, after the ADC has driven the bit on the falling SCLK.
            if (r_phase) begin
               r_sh_a <= w_sh_a;
               r_sh_b <= w_sh_b;
               r_bit  <= r_bit + 1'b1;
               if (w_chan_end) begin
                  r_bit    <= '0;
                  r_chan   <= r_chan + 1'b1;
                  r_data_a <= w_sh_a;
                  r_data_b <= w_sh_b;
                  r_chan_a <= W_CHS'(r_chan);
                  r_chan_b <= W_CHS'(r_chan) + W_CHS'(N_PER_LINE);
                  r_valid  <= 1'b1;
               end
            end
         end else begin
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_chan  <= '0;
         end
      end
   end

   assign os_out         = r_os;
   assign data_valid_out = r_valid;
   assign data_a_out     = r_data_a;
   assign data_b_out     = r_data_b;
   assign chan_a_out     = r_chan_a;
   assign chan_b_out     = r_chan_b;
   assign cycle_done_out = r_done;
   assign timeout_out    = r_timeout;

endmodule

// File: tb/tb_adc_controller.sv
// Self-checking bench for adc_controller: cycle-timeline reference model, randomized frames,
// directed reset / sign-extreme / ignored-start / mid-frame-reset / stuck-BUSY scenarios.
module tb_adc_controller;

   localparam int W         = 18;
   localparam int NPL       = 4;
   localparam int NB        = NPL * W;
   localparam int T_CONVST  = 4;
   localparam int T_RST     = 8;
   localparam int T_TIMEOUT = 1000;
   localparam int BIG       = 32'h3000_0000;

   logic          clk_in = 1'b0;
   logic          reset_in;
   logic          cstart_in;
   logic [2:0]    os_in;
   logic          busy_in;
   logic          douta_in;
   logic          doutb_in;
   logic          cvst_out;
   logic          ncs_out;
   logic          sclk_out;
   logic          adc_reset_out;
   logic [2:0]    os_out;
   logic          data_valid_out;
   logic [W-1:0]  data_a_out;
   logic [2:0]    chan_a_out;
   logic [W-1:0]  data_b_out;
   logic [2:0]    chan_b_out;
   logic          cycle_done_out;
   logic          timeout_out;

   always #5 clk_in = ~clk_in;

   adc_controller #(
      .W_DATA(W), .W_CHS(3), .N_CHAN(2 * NPL),
      .T_CONVST(T_CONVST), .T_RST(T_RST), .T_TIMEOUT(T_TIMEOUT)
   ) dut (
      .clk_in(clk_in), .reset_in(reset_in), .cstart_in(cstart_in), .os_in(os_in),
      .busy_in(busy_in), .douta_in(douta_in), .doutb_in(doutb_in),
      .cvst_out(cvst_out), .ncs_out(ncs_out), .sclk_out(sclk_out),
      .adc_reset_out(adc_reset_out), .os_out(os_out), .data_valid_out(data_valid_out),
      .data_a_out(data_a_out), .chan_a_out(chan_a_out), .data_b_out(data_b_out),
      .chan_b_out(chan_b_out), .cycle_done_out(cycle_done_out), .timeout_out(timeout_out)
   );

   // Frame plan: cycle numbers on the bench's own timeline (cycle n = interval after posedge n).
   int           cyc    = 0;
   int           cmp_n  = 0;
   int           err_n  = 0;
   int           rst_r0 = 0;
   int           rst_r1 = 2;
   bit           fr_on  = 1'b0;
   int           fr_n   = 0;
   int           fr_bh  = 0;
   int           fr_bl  = 0;
   int           fr_c   = BIG;
   int           fr_cut = BIG;
   int           fr_to  = BIG;
   int           ign_cyc = -1;
   logic [2:0]   fr_os  = '0;
   logic [W-1:0] fr_wa[NPL];
   logic [W-1:0] fr_wb[NPL];

   // Held model outputs
   logic [W-1:0] e_da = '0;
   logic [W-1:0] e_db = '0;
   logic [2:0]   e_ca = '0;
   logic [2:0]   e_cb = '0;
   logic [2:0]   e_os = '0;

   typedef struct {
      int           t;
      logic [W-1:0] da;
      logic [2:0]   ca;
      logic [W-1:0] db;
      logic [2:0]   cb;
   } strobe_t;
   strobe_t sq[$];
   int      done_t   = -1;
   int      cv_fall  = -1;
   int      cv_cnt   = 0;
   logic    prev_cv  = 1'b1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic drive();
      int i;
      reset_in  = (cyc >= rst_r0) && (cyc <= rst_r1);
      os_in     = 3'($urandom);
      if (fr_on && cyc == fr_n) fr_os = os_in;
      cstart_in = (fr_on && cyc == fr_n) || (cyc == ign_cyc);
      busy_in   = fr_on && (cyc >= fr_bh) && (cyc < fr_bl);
      if (fr_on && cyc >= fr_c + 1 && cyc <= fr_c + 2 * NB) begin
         i        = (cyc - fr_c - 1) / 2;
         douta_in = fr_wa[i / W][W - 1 - (i % W)];
         doutb_in = fr_wb[i / W][W - 1 - (i % W)];
      end else begin
         douta_in = 1'($urandom);
         doutb_in = 1'($urandom);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      cyc++;
      #1;
      drive();
   endtask

   // Compare every cycle against the timeline model
   always @(negedge clk_in) begin
      if (cyc >= 1) begin
         bit live;
         bit e_adc, e_cvst, e_ncs, e_sclk, e_valid, e_done, e_to;
         int t;
         t      = cyc;
         live   = fr_on && (t > fr_n) && (t <= fr_cut);
         e_adc  = (t >= rst_r0 + 1) && (t <= rst_r1 + T_RST);
         if (t >= rst_r0 + 1 && t <= rst_r1 + 1) begin
            e_da = '0; e_db = '0; e_ca = '0; e_cb = '0; e_os = '0;
         end
         e_cvst  = !(live && t >= fr_n + 1 && t <= fr_n + T_CONVST);
         e_ncs   = !(live && t >= fr_c && t <= fr_c + 2 * NB);
         e_sclk  = !(live && t >= fr_c + 1 && t <= fr_c + 2 * NB && ((t - fr_c - 1) % 2 == 0));
         e_valid = 1'b0;
         if (live && t == fr_n + 1) e_os = fr_os;
         for (int k = 0; k < NPL; k++) begin
            if (live && t == fr_c + 2 * W * (k + 1) + 1) begin
               e_valid = 1'b1;
               e_da    = fr_wa[k];
               e_db    = fr_wb[k];
               e_ca    = 3'(k);
               e_cb    = 3'(k + NPL);
            end
         end
         e_done = live && (t == fr_c + 2 * NB + 2);
         e_to   = live && (t == fr_to);

         check("adc_reset", 32'(adc_reset_out), 32'(e_adc));
         check("cvst", 32'(cvst_out), 32'(e_cvst));
         check("ncs", 32'(ncs_out), 32'(e_ncs));
         check("sclk", 32'(sclk_out), 32'(e_sclk));
         check("os", 32'(os_out), 32'(e_os));
         check("valid", 32'(data_valid_out), 32'(e_valid));
         check("data_a", 32'(data_a_out), 32'(e_da));
         check("data_b", 32'(data_b_out), 32'(e_db));
         check("chan_a", 32'(chan_a_out), 32'(e_ca));
         check("chan_b", 32'(chan_b_out), 32'(e_cb));
         check("done", 32'(cycle_done_out), 32'(e_done));
         check("timeout", 32'(timeout_out), 32'(e_to));

         if (data_valid_out)
            sq.push_back('{t: t, da: data_a_out, ca: chan_a_out, db: data_b_out, cb: chan_b_out});
         if (cycle_done_out) done_t = t;
         if (prev_cv && !cvst_out) begin
            cv_fall = t;
            cv_cnt++;
         end
         prev_cv = cvst_out;
      end
   end

   task automatic run_frame(input int d1, input int blen, input int gap, input bit ign,
                            input int rst_at);
      int stop;
      sq.delete();
      done_t  = -1;
      cv_cnt  = 0;
      cv_fall = -1;
      fr_on   = 1'b1;
      fr_n    = cyc + 1 + gap;
      fr_bh   = fr_n + T_CONVST + 1 + d1;
      fr_bl   = fr_bh + blen;
      fr_c    = fr_bl + 1;
      fr_cut  = BIG;
      fr_to   = BIG;
`ifdef ADC_TIMEOUT_EN
      if (fr_bl >= fr_n + T_CONVST + T_TIMEOUT) begin
         fr_to  = fr_n + T_CONVST + 1 + T_TIMEOUT;
         fr_c   = BIG;
         fr_cut = fr_to;
      end
`endif
      ign_cyc = -1;
      if (ign && rst_at < 0 && fr_c != BIG)
         ign_cyc = int'($urandom_range(32'(fr_c + 140), 32'(fr_n + 1)));
      if (rst_at >= 0) begin
         rst_r0 = fr_c + 2 * W * 2 + 1 + rst_at;
         rst_r1 = rst_r0 + 2;
         fr_cut = rst_r0;
         stop   = rst_r1 + T_RST + 2;
      end else if (fr_c == BIG) begin
         stop = fr_bl + 2;
      end else begin
         stop = fr_c + 2 * NB + 3;
      end
      while (cyc < stop) tick();
   endtask

   task automatic load_words(input logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
      fr_wa[0] = a0; fr_wa[1] = a1; fr_wa[2] = a2; fr_wa[3] = a3;
      fr_wb[0] = b0; fr_wb[1] = b1; fr_wb[2] = b2; fr_wb[3] = b3;
   endtask

   initial begin
      drive();
      // Reset sequencing: 3 cycles of reset_in, ADC reset held for T_RST cycles afterwards
      while (cyc < 10) tick();
      check("adc_rst_tail", 32'(adc_reset_out), 32'd1);
      tick();
      check("adc_rst_end", 32'(adc_reset_out), 32'd0);
      check("ncs_idle", 32'(ncs_out), 32'd1);
      tick();

      // Nominal frame: alternating patterns, BUSY high 2 cycles after CONVST for 50 cycles
      load_words(18'h2AAAA, 18'h15555, 18'h2AAAA, 18'h15555,
                 18'h15555, 18'h2AAAA, 18'h15555, 18'h2AAAA);
      run_frame(1, 50, 2, 1'b0, -1);
      check("nom_strobes", 32'(sq.size()), 32'd4);
      check("nom_cv_latency", 32'(cv_fall - fr_n), 32'd1);
      if (sq.size() == 4) begin
         check("nom_gap01", 32'(sq[1].t - sq[0].t), 32'd36);
         check("nom_gap23", 32'(sq[3].t - sq[2].t), 32'd36);
         check("nom_a0", 32'(sq[0].da), 32'h2AAAA);
         check("nom_b0", 32'(sq[0].db), 32'h15555);
         check("nom_a1", 32'(sq[1].da), 32'h15555);
         check("nom_ca3", 32'(sq[3].ca), 32'd3);
         check("nom_cb3", 32'(sq[3].cb), 32'd7);
         check("nom_done_lag", 32'(done_t - sq[3].t), 32'd1);
      end

      // Sign extremes plus a start request that lands mid-frame and must be ignored
      load_words(18'h3FFFF, 18'h00000, 18'h20000, 18'h1FFFF,
                 18'h1FFFF, 18'h20000, 18'h00000, 18'h3FFFF);
      run_frame(0, 20, 3, 1'b0, -1);
      ign_cyc = fr_c + 50;
      check("ext_strobes", 32'(sq.size()), 32'd4);
      if (sq.size() == 4) begin
         check("ext_a0", 32'(sq[0].da), 32'h3FFFF);
         check("ext_a2", 32'(sq[2].da), 32'h20000);
         check("ext_a3", 32'(sq[3].da), 32'h1FFFF);
         check("ext_b1", 32'(sq[1].db), 32'h20000);
      end
      ign_cyc = -1;
      load_words(18'h3FFFF, 18'h00000, 18'h20000, 18'h1FFFF,
                 18'h1FFFF, 18'h20000, 18'h00000, 18'h3FFFF);
      run_frame(2, 30, 1, 1'b1, -1);
      check("ign_one_convst", 32'(cv_cnt), 32'd1);

      // Mid-frame reset after the second strobe, then a clean frame
      for (int k = 0; k < NPL; k++) begin
         fr_wa[k] = W'($urandom);
         fr_wb[k] = W'($urandom);
      end
      run_frame(1, 10, 2, 1'b0, 5);
      check("rst_strobes", 32'(sq.size()), 32'd2);
      for (int k = 0; k < NPL; k++) begin
         fr_wa[k] = W'($urandom);
         fr_wb[k] = W'($urandom);
      end
      run_frame(0, 5, 1, 1'b0, -1);
      check("post_rst_strobes", 32'(sq.size()), 32'd4);

      // Randomized frames
      for (int f = 0; f < 10; f++) begin
         for (int k = 0; k < NPL; k++) begin
            fr_wa[k] = W'($urandom);
            fr_wb[k] = W'($urandom);
         end
         run_frame(int'($urandom_range(3, 0)), int'($urandom_range(60, 1)),
                   int'($urandom_range(20, 1)), 1'($urandom), -1);
      end

      // BUSY stuck high beyond the timeout budget
      for (int k = 0; k < NPL; k++) begin
         fr_wa[k] = W'($urandom);
         fr_wb[k] = W'($urandom);
      end
      run_frame(0, T_TIMEOUT + 100, 2, 1'b0, -1);
`ifdef ADC_TIMEOUT_EN
      check("stuck_strobes", 32'(sq.size()), 32'd0);
`else
      check("stuck_strobes", 32'(sq.size()), 32'd4);
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
